// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU:
// opcode values and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ITER
  } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative MUL/DIV datapath: shift-add multiply and restoring divide,
// one step per cycle; result/flag show the value the final step will write.
import alu_pkg::*;

module alu_iter_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             finish,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic                 active;
  logic                 div_r;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc_n;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     dvs;
  logic [WIDTH-1:0]     rem_n;
  logic [WIDTH-1:0]     quo_n;
  logic [WIDTH:0]       trial;

  // One multiply step and one restoring-divide step from current state.
  always_comb begin
    acc_n = mplier[0] ? acc + mcand : acc;
    trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    if (!trial[WIDTH])
      rem_n = trial[WIDTH-1:0];
    else
      rem_n = {rem[WIDTH-2:0], quo[WIDTH-1]};
    quo_n = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

  assign finish = active & (cnt == LAST);
  assign result = div_r ? quo_n : acc_n[WIDTH-1:0];
  assign flag   = div_r ? (dvs == '0)
                        : (|acc_n[2*WIDTH-1:WIDTH]);

  // Load operands on go, then iterate until the last step is taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      active <= 1'b0;
      div_r  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
    end else if (go) begin
      active <= 1'b1;
      div_r  <= is_div;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      rem    <= '0;
      quo    <= a;
      dvs    <= b;
    end else if (active) begin
      acc    <= acc_n;
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      rem    <= rem_n;
      quo    <= quo_n;
      cnt    <= cnt + CW'(1);
      if (finish)
        active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with start/busy/done handshake; single-cycle ops
// complete in one cycle, MUL/DIV run through alu_iter_unit.
import alu_pkg::*;

module alu_multicycle #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       aluOpcode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aluResult,
  output logic             Zero,
  output logic             Carry
);

  state_t           state;
  state_t           state_n;
  logic             done_r;
  logic [WIDTH-1:0] res_r;
  logic             zero_r;
  logic             carry_r;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             is_iter;

  logic             go;
  logic             load;
  logic [WIDTH-1:0] nxt_res;
  logic             nxt_c;

  logic             finish;
  logic [WIDTH-1:0] it_res;
  logic             it_flag;

  assign sum     = {1'b0, A} + {1'b0, B};
  assign dif     = {1'b0, A} - {1'b0, B};
  assign is_iter = (aluOpcode == OP_MUL) | (aluOpcode == OP_DIV);

  // Single-cycle results straight from the inputs at accept.
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    case (aluOpcode)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
      end
      OP_SUB: begin
        sc_res = dif[WIDTH-1:0];
        sc_c   = dif[WIDTH];
      end
      OP_AND: sc_res = A & B;
      OP_OR:  sc_res = A | B;
      OP_XOR: sc_res = A ^ B;
      OP_NOT: sc_res = ~A;
      OP_SHL: begin
        sc_res = {A[WIDTH-2:0], 1'b0};
        sc_c   = A[WIDTH-1];
      end
      OP_SHR: begin
        sc_res = {1'b0, A[WIDTH-1:1]};
        sc_c   = A[0];
      end
      default: begin
        sc_res = '0;
        sc_c   = 1'b0;
      end
    endcase
  end

  alu_iter_unit #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clock  (clock),
    .reset  (reset),
    .go     (go),
    .is_div (aluOpcode == OP_DIV),
    .a      (A),
    .b      (B),
    .finish (finish),
    .result (it_res),
    .flag   (it_flag)
  );

  // Next state and result-load decision; done follows load by one edge.
  always_comb begin
    state_n = state;
    go      = 1'b0;
    load    = 1'b0;
    nxt_res = '0;
    nxt_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !done_r) begin
          if (is_iter) begin
            state_n = ITER;
            go      = 1'b1;
          end else begin
            state_n = EXEC;
            load    = 1'b1;
            nxt_res = sc_res;
            nxt_c   = sc_c;
          end
        end
      end
      EXEC: state_n = IDLE;
      ITER: begin
        if (finish) begin
          state_n = IDLE;
          load    = 1'b1;
          nxt_res = it_res;
          nxt_c   = it_flag;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; flags are rewritten with every result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      done_r  <= 1'b0;
      res_r   <= '0;
      zero_r  <= 1'b0;
      carry_r <= 1'b0;
    end else begin
      state  <= state_n;
      done_r <= load;
      if (load) begin
        res_r   <= nxt_res;
        zero_r  <= (nxt_res == '0);
        carry_r <= nxt_c;
      end
    end
  end

  assign busy      = (state != IDLE) | done_r;
  assign done      = done_r;
  assign aluResult = res_r;
  assign Zero      = zero_r;
  assign Carry     = carry_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle,
// covering WIDTH=4 and WIDTH=8 instances.
module tb_alu_multicycle;

  logic       clock;
  logic       reset;
  logic       s4, s8;
  logic [3:0] a4, b4, op4;
  logic [7:0] a8, b8;
  logic [3:0] op8;
  logic       busy4, done4, z4, c4;
  logic       busy8, done8, z8, c8;
  logic [3:0] r4;
  logic [7:0] r8;

  int compared;
  int mism;

  alu_multicycle #(.WIDTH(4)) dut4 (
    .clock     (clock),
    .reset     (reset),
    .start     (s4),
    .A         (a4),
    .B         (b4),
    .aluOpcode (op4),
    .busy      (busy4),
    .done      (done4),
    .aluResult (r4),
    .Zero      (z4),
    .Carry     (c4)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clock     (clock),
    .reset     (reset),
    .start     (s8),
    .A         (a8),
    .B         (b8),
    .aluOpcode (op8),
    .busy      (busy8),
    .done      (done8),
    .aluResult (r8),
    .Zero      (z8),
    .Carry     (c8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input int w, input logic s,
                        input logic [3:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b);
    if (w == 4) begin
      s4 = s; op4 = op; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      s8 = s; op8 = op; a8 = a; b8 = b;
    end
  endtask

  task automatic get(input int w, output logic d,
                     output logic bz, output logic [7:0] r,
                     output logic z, output logic c);
    if (w == 4) begin
      d = done4; bz = busy4; r = {4'd0, r4}; z = z4; c = c4;
    end else begin
      d = done8; bz = busy8; r = r8; z = z8; c = c8;
    end
  endtask

  task automatic run_op(input int w, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ez,
                        input logic ec, input int elat,
                        input string tag);
    int lat;
    logic d, bz, z, c;
    logic [7:0] r;
    get(w, d, bz, r, z, c);
    chk({tag, " idle"}, bz, 0);
    set_in(w, 1'b1, op, a, b);
    step();
    set_in(w, 1'b0, 4'd0, 8'd0, 8'd0);
    lat = 1;
    get(w, d, bz, r, z, c);
    while (!d && lat < 40) begin
      step();
      lat++;
      get(w, d, bz, r, z, c);
    end
    chk({tag, " done"}, d, 1);
    chk({tag, " lat"}, lat, elat);
    chk({tag, " busy"}, bz, 1);
    chk({tag, " res"}, r, er);
    chk({tag, " zero"}, z, ez);
    chk({tag, " carry"}, c, ec);
    step();
    get(w, d, bz, r, z, c);
    chk({tag, " pulse"}, d, 0);
  endtask

  initial begin
    int lat;
    int ndone;
    logic d, bz, z, c;
    logic [7:0] r;
    compared = 0;
    mism = 0;
    reset = 1'b1;
    set_in(4, 1'b0, 4'd0, 8'd0, 8'd0);
    set_in(8, 1'b0, 4'd0, 8'd0, 8'd0);
    step();
    step();
    get(4, d, bz, r, z, c);
    chk("rst busy", bz, 0);
    chk("rst done", d, 0);
    chk("rst res", r, 0);
    chk("rst zero", z, 0);
    chk("rst carry", c, 0);
    reset = 1'b0;

    run_op(4, 4'd0, 9, 3, 12, 0, 0, 1, "add9_3");
    run_op(4, 4'd0, 15, 15, 14, 0, 1, 1, "add15_15");
    run_op(4, 4'd1, 9, 9, 0, 1, 0, 1, "sub9_9");
    run_op(4, 4'd1, 3, 9, 10, 0, 1, 1, "sub3_9");
    run_op(4, 4'd2, 12, 10, 8, 0, 0, 1, "and");
    run_op(4, 4'd3, 12, 10, 14, 0, 0, 1, "or");
    run_op(4, 4'd4, 12, 10, 6, 0, 0, 1, "xor");
    run_op(4, 4'd5, 5, 0, 10, 0, 0, 1, "not");
    run_op(4, 4'd6, 9, 0, 2, 0, 1, 1, "shl");
    run_op(4, 4'd7, 9, 0, 4, 0, 1, 1, "shr");
    run_op(4, 4'd12, 7, 7, 0, 1, 0, 1, "rsvd");
    run_op(4, 4'd8, 9, 3, 11, 0, 1, 5, "mul9_3");
    run_op(4, 4'd8, 3, 5, 15, 0, 0, 5, "mul3_5");
    run_op(4, 4'd9, 9, 3, 3, 0, 0, 5, "div9_3");
    run_op(4, 4'd9, 7, 0, 15, 0, 1, 5, "div7_0");

    // ADD pulses during a MUL and in its done cycle are ignored.
    set_in(4, 1'b1, 4'd8, 9, 3);
    step();
    set_in(4, 1'b0, 4'd0, 0, 0);
    step();
    set_in(4, 1'b1, 4'd0, 1, 1);
    step();
    set_in(4, 1'b0, 4'd0, 0, 0);
    lat = 3;
    get(4, d, bz, r, z, c);
    while (!d && lat < 40) begin
      step();
      lat++;
      get(4, d, bz, r, z, c);
    end
    chk("ign lat", lat, 5);
    chk("ign res", r, 11);
    chk("ign carry", c, 1);
    set_in(4, 1'b1, 4'd0, 1, 1);
    step();
    set_in(4, 1'b0, 4'd0, 0, 0);
    get(4, d, bz, r, z, c);
    chk("ign2 done", d, 0);
    chk("ign2 busy", bz, 0);
    step();
    get(4, d, bz, r, z, c);
    chk("ign3 done", d, 0);
    chk("ign3 res", r, 11);

    // Reset in the middle of a MUL aborts it.
    set_in(4, 1'b1, 4'd8, 3, 5);
    step();
    set_in(4, 1'b0, 4'd0, 0, 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    get(4, d, bz, r, z, c);
    chk("abort busy", bz, 0);
    chk("abort done", d, 0);
    chk("abort res", r, 0);
    chk("abort zero", z, 0);
    chk("abort carry", c, 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      get(4, d, bz, r, z, c);
      if (d) ndone++;
    end
    chk("abort nodone", ndone, 0);
    run_op(4, 4'd0, 9, 3, 12, 0, 0, 1, "post_rst");

    run_op(8, 4'd0, 9, 3, 12, 0, 0, 1, "w8 add9_3");
    run_op(8, 4'd0, 200, 100, 44, 0, 1, 1, "w8 add_c");
    run_op(8, 4'd1, 9, 9, 0, 1, 0, 1, "w8 sub9_9");
    run_op(8, 4'd1, 3, 9, 250, 0, 1, 1, "w8 sub3_9");
    run_op(8, 4'd8, 200, 2, 144, 0, 1, 9, "w8 mul200_2");
    run_op(8, 4'd8, 3, 5, 15, 0, 0, 9, "w8 mul3_5");
    run_op(8, 4'd9, 9, 3, 3, 0, 0, 9, "w8 div9_3");
    run_op(8, 4'd9, 200, 7, 28, 0, 0, 9, "w8 div200_7");
    run_op(8, 4'd9, 7, 0, 255, 0, 1, 9, "w8 div7_0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
